// File: rtl/reg_bank_slave.sv
// Register bank slave: RW, read-only and write-1-to-clear registers
// behind a wait-stated single-outstanding request/ready bus.
module reg_bank_slave #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1,
    parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]        W1C_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reg_wr,
    input  logic                       reg_rd,
    input  logic [ADDR_W-1:0]          reg_addr,
    input  logic [DATA_W-1:0]          reg_wdata,
    output logic [DATA_W-1:0]          reg_rdata,
    output logic                       reg_ready,
    output logic                       reg_err,
    input  logic [NUM_REGS*DATA_W-1:0] hw_ro_val,
    input  logic [NUM_REGS*DATA_W-1:0] hw_set,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_strobe
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                cap_en;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                cap_wr, cap_rd;
    logic [NUM_REGS-1:0] hit;
    logic [DATA_W-1:0]   rd_val;
    logic                resp, err_c, do_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (reg_wr || reg_rd) begin
                    cap_en    = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
            cap_rd    <= 1'b0;
        end else if (cap_en) begin
            cap_addr  <= reg_addr;
            cap_wdata <= reg_wdata;
            cap_wr    <= reg_wr;
            cap_rd    <= reg_rd;
        end
    end

    // An empty hit vector means the address is beyond the implemented bank
    assign resp  = (state == RESP);
    assign err_c = (cap_wr & cap_rd) | ~(|hit) | (cap_wr & |(hit & RO_MASK));
    assign do_wr = resp & cap_wr & ~err_c;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign hit[i] = (cap_addr == ADDR_W'(i));
        if (RO_MASK[i]) begin : g_ro
            logic unused_ro;
            assign unused_ro = ^hw_set[i*DATA_W +: DATA_W];
            assign reg_q[i*DATA_W +: DATA_W] = hw_ro_val[i*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] q;
            logic              commit;
            logic              unused_rw;
            assign unused_rw = ^hw_ro_val[i*DATA_W +: DATA_W];
            assign commit    = do_wr & hit[i];
            // Set is OR-ed after the clear so a same-cycle set wins
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= RESET_VAL[i*DATA_W +: DATA_W];
                else if (W1C_MASK[i])
                    q <= (commit ? (q & ~cap_wdata) : q)
                         | hw_set[i*DATA_W +: DATA_W];
                else if (commit)
                    q <= cap_wdata;
            end
            assign reg_q[i*DATA_W +: DATA_W] = q;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (hit[i]) rd_val = reg_q[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ready <= 1'b0;
            reg_err   <= 1'b0;
            reg_rdata <= '0;
            wr_strobe <= '0;
        end else begin
            reg_ready <= resp;
            reg_err   <= resp & err_c;
            reg_rdata <= (resp && cap_rd && !err_c) ? rd_val : '0;
            wr_strobe <= do_wr ? hit : '0;
        end
    end

endmodule

// File: tb/tb_reg_bank_slave.sv
// Directed bench for reg_bank_slave: vector table plus W1C, reset-abort
// and back-to-back (zero wait state) sequences.
module tb_reg_bank_slave;

    localparam int NR = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reg_wr, reg_rd;
    logic [3:0]    reg_addr;
    logic [7:0]    reg_wdata, reg_rdata;
    logic          reg_ready, reg_err;
    logic [NR*8-1:0] hw_ro_val, hw_set, reg_q;
    logic [NR-1:0] wr_strobe;

    logic          wr0, rd0;
    logic [3:0]    addr0;
    logic [7:0]    wdata0, rdata0;
    logic          ready0, err0;
    logic [NR*8-1:0] q0;
    logic [NR-1:0] strobe0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_slave #(
        .ADDR_W(4), .DATA_W(8), .NUM_REGS(NR), .WAIT_CYCLES(2),
        .RO_MASK(12'h008), .W1C_MASK(12'h020), .RESET_VAL('0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_ready(reg_ready), .reg_err(reg_err), .hw_ro_val(hw_ro_val),
        .hw_set(hw_set), .reg_q(reg_q), .wr_strobe(wr_strobe)
    );

    reg_bank_slave #(
        .ADDR_W(4), .DATA_W(8), .NUM_REGS(NR), .WAIT_CYCLES(0),
        .RO_MASK(12'h008), .W1C_MASK(12'h020), .RESET_VAL('0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .reg_wr(wr0), .reg_rd(rd0),
        .reg_addr(addr0), .reg_wdata(wdata0), .reg_rdata(rdata0),
        .reg_ready(ready0), .reg_err(err0), .hw_ro_val(hw_ro_val),
        .hw_set(hw_set), .reg_q(q0), .wr_strobe(strobe0)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
        logic [11:0] strobe;
        logic [7:0]  q;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic txn(input string tag, input vec_t v);
        int n;
        bit got;
        logic [7:0] rd_s;
        logic err_s;
        logic [11:0] st_s;
        n = 0;
        got = 0;
        rd_s = '0;
        err_s = 1'b0;
        st_s = '0;
        @(negedge clk);
        reg_wr = v.wr;
        reg_rd = v.rd;
        reg_addr = v.addr;
        reg_wdata = v.wdata;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                reg_addr = 4'hE;
                reg_wdata = ~v.wdata;
            end
            if (reg_ready) begin
                got = 1;
                rd_s = reg_rdata;
                err_s = reg_err;
                st_s = wr_strobe;
            end
        end
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        chk({tag, " latency"}, n, 4);
        chk({tag, " rdata"}, rd_s, v.rdata);
        chk({tag, " err"}, err_s, v.err);
        chk({tag, " strobe"}, st_s, v.strobe);
        if (v.addr < 4'(NR))
            chk({tag, " reg_q"}, reg_q[v.addr*8 +: 8], v.q);
        @(posedge clk);
        #1;
        chk({tag, " single pulse"}, {reg_ready, reg_err, reg_rdata, wr_strobe}, 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        reg_wr = 0; reg_rd = 0; reg_addr = '0; reg_wdata = '0;
        wr0 = 0; rd0 = 0; addr0 = '0; wdata0 = '0;
        hw_ro_val = {NR{8'h77}};
        hw_ro_val[3*8 +: 8] = 8'h3C;
        hw_set = '0;

        //        wr rd addr   wdata  rdata  err strobe    q
        vt[0]  = '{1, 0, 4'd2,  8'hA5, 8'h00, 0, 12'h004, 8'hA5};
        vt[1]  = '{0, 1, 4'd2,  8'h00, 8'hA5, 0, 12'h000, 8'hA5};
        vt[2]  = '{0, 1, 4'd3,  8'h00, 8'h3C, 0, 12'h000, 8'h3C};
        vt[3]  = '{1, 0, 4'd3,  8'hFF, 8'h00, 1, 12'h000, 8'h3C};
        vt[4]  = '{0, 1, 4'd13, 8'h00, 8'h00, 1, 12'h000, 8'h00};
        vt[5]  = '{1, 1, 4'd2,  8'h00, 8'h00, 1, 12'h000, 8'hA5};
        vt[6]  = '{0, 1, 4'd2,  8'h00, 8'hA5, 0, 12'h000, 8'hA5};
        vt[7]  = '{1, 0, 4'd12, 8'h33, 8'h00, 1, 12'h000, 8'h00};
        vt[8]  = '{1, 0, 4'd0,  8'h5A, 8'h00, 0, 12'h001, 8'h5A};
        vt[9]  = '{0, 1, 4'd0,  8'h00, 8'h5A, 0, 12'h000, 8'h5A};
        vt[10] = '{1, 0, 4'd0,  8'h00, 8'h00, 0, 12'h001, 8'h00};
        vt[11] = '{0, 1, 4'd7,  8'h00, 8'h00, 0, 12'h000, 8'h00};

        #22;
        chk("reset outputs", {reg_ready, reg_err, reg_rdata, wr_strobe}, 0);
        chk("reset reg2", reg_q[2*8 +: 8], 8'h00);
        chk("reset ro3", reg_q[3*8 +: 8], 8'h3C);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            txn($sformatf("vec%0d", i), vt[i]);

        // W1C register 5 and hw_set on a plain RW register
        @(negedge clk);
        hw_set[5*8 +: 8] = 8'h81;
        hw_set[2*8 +: 8] = 8'hFF;
        @(negedge clk);
        hw_set = '0;
        chk("w1c set", reg_q[5*8 +: 8], 8'h81);
        chk("rw ignores set", reg_q[2*8 +: 8], 8'hA5);
        txn("w1c clr01", '{1, 0, 4'd5, 8'h01, 8'h00, 0, 12'h020, 8'h80});
        hw_set[5*8 +: 8] = 8'h80;
        txn("w1c set wins", '{1, 0, 4'd5, 8'h80, 8'h00, 0, 12'h020, 8'h80});
        @(negedge clk);
        hw_set = '0;
        @(negedge clk);
        chk("w1c after set", reg_q[5*8 +: 8], 8'h80);
        txn("w1c read", '{0, 1, 4'd5, 8'hFF, 8'h80, 0, 12'h000, 8'h80});
        txn("w1c clr80", '{1, 0, 4'd5, 8'h80, 8'h00, 0, 12'h020, 8'h00});

        // Reset during WAIT aborts the write
        @(negedge clk);
        reg_wr = 1'b1;
        reg_addr = 4'd0;
        reg_wdata = 8'h11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        reg_wr = 1'b0;
        chk("rst ready", reg_ready, 1'b0);
        chk("rst reg0", reg_q[0*8 +: 8], 8'h00);
        chk("rst reg2", reg_q[2*8 +: 8], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (reg_ready || wr_strobe != 0) seen++;
        end
        chk("aborted txn quiet", seen, 0);
        txn("post rst read", '{0, 1, 4'd0, 8'h00, 8'h00, 0, 12'h000, 8'h00});

        // Back-to-back writes with zero wait states
        seen = 0;
        @(negedge clk);
        wr0 = 1'b1;
        addr0 = 4'd1;
        wdata0 = 8'd0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b ready k%0d", k), ready0, 1'((k % 2) == 1));
            if (strobe0[1]) seen++;
            @(negedge clk);
            wdata0 = 8'(k + 1);
        end
        wr0 = 1'b0;
        chk("b2b strobes", seen, 5);
        chk("b2b final reg1", q0[1*8 +: 8], 8'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_slave.md
REG_BANK_SLAVE -- requirements
Module: reg_bank_slave

Interface
REQ-001 Parameter ADDR_W, default 4, register address width.
REQ-002 Parameter DATA_W, default 8, register data width.
REQ-003 Parameter NUM_REGS, default 16, number of implemented registers; SHALL satisfy 1 <= NUM_REGS <= 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 1, wait states inserted before reg_ready; legal range 0..15.
REQ-005 Parameter RO_MASK, default 0, NUM_REGS bits; bit i = 1 makes register i read-only.
REQ-006 Parameter W1C_MASK, default 0, NUM_REGS bits; bit i = 1 makes register i write-1-to-clear; RO_MASK takes precedence.
REQ-007 Parameter RESET_VAL, default 0, NUM_REGS*DATA_W bits; reset value of each RW/W1C register.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 reg_wr  input  1  write request; held until reg_ready.
REQ-011 reg_rd  input  1  read request; held until reg_ready.
REQ-012 reg_addr  input  ADDR_W  register index.
REQ-013 reg_wdata  input  DATA_W  write data.
REQ-014 reg_rdata  output  DATA_W  read data; valid only while reg_ready = 1.
REQ-015 reg_ready  output  1  one-cycle completion pulse.
REQ-016 reg_err  output  1  error flag; valid only while reg_ready = 1.
REQ-017 hw_ro_val  input  NUM_REGS*DATA_W  live value for each RO register.
REQ-018 hw_set  input  NUM_REGS*DATA_W  per-bit set requests for W1C registers; ignored for other registers.
REQ-019 reg_q  output  NUM_REGS*DATA_W  current value of every register (RO slices = hw_ro_val).
REQ-020 wr_strobe  output  NUM_REGS  one-cycle pulse per register on each committed write.

Function
REQ-021 FSM states: IDLE, WAIT, RESP.
- IDLE: on a sampled reg_wr|reg_rd, capture addr/wdata/op, load counter = WAIT_CYCLES, go to WAIT (or to RESP if WAIT_CYCLES = 0).
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP: go to IDLE unconditionally.
REQ-022 Latency: request sampled at edge N -> reg_ready high during the cycle after edge N+1+WAIT_CYCLES, for exactly one cycle.
REQ-023 Captured address/data SHALL be used; changes on the bus after capture SHALL be ignored.
REQ-024 No request is accepted in WAIT or RESP; a request still high in the cycle after RESP SHALL start a new transaction, giving a minimum spacing of 2+WAIT_CYCLES cycles.
REQ-025 Write commit at the RESP edge:
- RW register: reg <= wdata.
- W1C register: reg <= (reg & ~wdata) | hw_set slice.
- wr_strobe[addr] SHALL pulse in the cycle after commit.
REQ-026 Error conditions assert reg_err = 1 with no state change and no wr_strobe:
- addr >= NUM_REGS, for either operation.
- write to an RO register.
- reg_wr and reg_rd both high at capture; this case also returns reg_rdata = 0.
REQ-027 Read: reg_rdata = register value (RO: hw_ro_val sampled at RESP) when the read is valid; 0 on error; 0 whenever reg_ready = 0.
REQ-028 hw_set bits OR into W1C registers every cycle; on a same-cycle clear and set of one bit, set wins.
REQ-029 Reads SHALL have no side effects.

Reset
REQ-030 rst_n low SHALL immediately force:
- FSM to IDLE and counter to 0;
- reg_ready, reg_err, reg_rdata and wr_strobe to 0;
- every RW/W1C register to its RESET_VAL slice.
REQ-031 Reset during WAIT or RESP SHALL abort the transaction with no write committed; the first request after rst_n rises SHALL be accepted normally.

Verification
Bench parameters for all scenarios: NUM_REGS=12, WAIT_CYCLES=2, RO_MASK bit 3, W1C_MASK bit 5, RESET_VAL=0.
REQ-032 Write 0xA5 to addr 2, then read addr 2 -> each reg_ready arrives 4 cycles after the request, err=0; read returns 0xA5; wr_strobe[2] pulses once.
REQ-033 hw_ro_val[3]=0x3C: read addr 3 -> 0x3C, err=0; write 0xFF to addr 3 -> err=1, value unchanged, no strobe.
REQ-034 hw_set pulses 0x81 into reg 5; write 0x01 -> reg 5 = 0x80; same-cycle write 0x80 and hw_set 0x80 -> reg 5 stays 0x80.
REQ-035 Read addr 13 (>= NUM_REGS) -> err=1, rdata=0x00; reg_wr and reg_rd both high on addr 2 -> err=1, reg 2 unchanged.
REQ-036 Write 0x11 to addr 0 with rst_n pulsed low during WAIT -> no ready, reg 0 = 0x00; next read of addr 0 -> 0x00 after 4 cycles.
REQ-037 Request held high for 10 cycles with WAIT_CYCLES=0 -> ready every 2nd cycle, one commit per ready.
